pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 27 ++
 rtl/pipe_hazard_ctrl_cmp.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// operand-forwarding select encoding and the register/counter widths.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDUSE   = 2'd1,
    MEMWAIT = 2'd2,
    ERR     = 2'd3
  } state_e;

  // Operand source for rs1/rs2 in EX.
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // The MEM result is younger than the WB result, so it wins when both match.
  function automatic logic [1:0] fwd_select(input logic hit_mem, input logic hit_wb);
    if (hit_mem) return FWD_MEM;
    if (hit_wb)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_cmp.sv
// hazard_cmp: matches one ID-stage source register against the EX, MEM and WB
// producers. x0 is hard-wired zero, so a zero source never reports a match.
module hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] dest_ex_i,
  input  logic       wen_ex_i,
  input  logic [4:0] dest_mem_i,
  input  logic       wen_mem_i,
  input  logic [4:0] dest_wb_i,
  input  logic       wen_wb_i,
  output logic       hit_ex_o,
  output logic       hit_mem_o,
  output logic       hit_wb_o
);

  logic rs_nonzero;

  // A nonzero source that equals a destination implies a nonzero destination.
  assign rs_nonzero = (rs_i != '0);
  assign hit_ex_o   = rs_nonzero & wen_ex_i  & (dest_ex_i  == rs_i);
  assign hit_mem_o  = rs_nonzero & wen_mem_i & (dest_mem_i == rs_i);
  assign hit_wb_o   = rs_nonzero & wen_wb_i  & (dest_wb_i  == rs_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward control for a 5-stage pipeline.
// Handles memory wait with timeout, taken-branch flush, load-use stall and,
// when forwarding is disabled, RAW stalls against EX/MEM producers.
// Build option: define PIPE_FORWARD_EN to enable MEM/WB operand forwarding.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic [4:0] dest_EX,
  input  logic       regwen_EX,
  input  logic       memread_EX,
  input  logic [4:0] dest_MEM,
  input  logic       regwen_MEM,
  input  logic       memacc_MEM,
  input  logic [4:0] dest_WB,
  input  logic       regwen_WB,
  input  logic       branch_taken_EX,
  input  logic       dmem_ack,
  output logic       stall_IF,
  output logic       stall_ID,
  output logic       flush_ID,
  output logic       flush_EX,
  output logic       stall_MEM,
  output logic [1:0] fwdA_sel,
  output logic [1:0] fwdB_sel,
  output logic       mem_err,
  output logic [1:0] state
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic hit_a_ex, hit_a_mem, hit_a_wb;
  logic hit_b_ex, hit_b_mem, hit_b_wb;
  logic load_use, raw_stall;
  logic [1:0] fwd_a, fwd_b;
  logic stall_fe_c, flush_id_c, flush_ex_c, stall_mem_c;

  hazard_cmp u_cmp_a (
    .rs_i      (rs1_ID),
    .dest_ex_i (dest_EX),
    .wen_ex_i  (regwen_EX),
    .dest_mem_i(dest_MEM),
    .wen_mem_i (regwen_MEM),
    .dest_wb_i (dest_WB),
    .wen_wb_i  (regwen_WB),
    .hit_ex_o  (hit_a_ex),
    .hit_mem_o (hit_a_mem),
    .hit_wb_o  (hit_a_wb)
  );

  hazard_cmp u_cmp_b (
    .rs_i      (rs2_ID),
    .dest_ex_i (dest_EX),
    .wen_ex_i  (regwen_EX),
    .dest_mem_i(dest_MEM),
    .wen_mem_i (regwen_MEM),
    .dest_wb_i (dest_WB),
    .wen_wb_i  (regwen_WB),
    .hit_ex_o  (hit_b_ex),
    .hit_mem_o (hit_b_mem),
    .hit_wb_o  (hit_b_wb)
  );

  assign load_use = memread_EX & (hit_a_ex | hit_b_ex);

`ifdef PIPE_FORWARD_EN
  // Forwarding covers every ALU producer; only a load in EX still needs a stall.
  assign raw_stall = 1'b0;
  assign fwd_a     = fwd_select(hit_a_mem, hit_a_wb);
  assign fwd_b     = fwd_select(hit_b_mem, hit_b_wb);
`else
  // Without forwarding, the consumer waits until the producer has left MEM.
  logic unused_wb_hits;
  assign unused_wb_hits = hit_a_wb ^ hit_b_wb;
  assign raw_stall      = hit_a_ex | hit_b_ex | hit_a_mem | hit_b_mem;
  assign fwd_a          = FWD_RF;
  assign fwd_b          = FWD_RF;
`endif

  // State register and memory wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values.
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and control decode; priority: memory wait > branch > load-use > RAW.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path infers a latch.
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_fe_c  = 1'b0;
    flush_id_c  = 1'b0;
    flush_ex_c  = 1'b0;
    stall_mem_c = 1'b0;

    case (state_q)
      RUN, LDUSE: begin
        state_d    = RUN;
        wait_cnt_d = '0;
        if (branch_taken_EX) begin
          flush_id_c = 1'b1;
          flush_ex_c = 1'b1;
        end else if ((state_q == RUN) && load_use) begin
          stall_fe_c = 1'b1;
          flush_ex_c = 1'b1;
          state_d    = LDUSE;
        end else if (raw_stall) begin
          stall_fe_c = 1'b1;
          flush_ex_c = 1'b1;
        end
        // An access acknowledged in its first cycle never enters the wait.
        if ((state_q == RUN) && memacc_MEM && !dmem_ack) begin
          state_d = MEMWAIT;
        end
      end

      MEMWAIT: begin
        stall_fe_c  = 1'b1;
        stall_mem_c = 1'b1;
        if (dmem_ack) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ERR;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ERR: begin
        stall_fe_c  = 1'b1;
        stall_mem_c = 1'b1;
      end

      default: state_d = RUN;
    endcase
  end

  // Outputs are forced low while reset is held, whatever the inputs do.
  assign stall_IF  = rst & stall_fe_c;
  assign stall_ID  = rst & stall_fe_c;
  assign flush_ID  = rst & flush_id_c;
  assign flush_EX  = rst & flush_ex_c;
  assign stall_MEM = rst & stall_mem_c;
  assign fwdA_sel  = rst ? fwd_a : FWD_RF;
  assign fwdB_sel  = rst ? fwd_b : FWD_RF;
  assign mem_err   = (state_q == ERR);
  assign state     = state_q;

endmodule
